prefetch_fetch_unit: RTL and testbench
======================================

# prefetch_fetch_unit

Parametrised instruction-fetch front end for the next-generation MIPS core. It replaces the single-cycle PC-register arrangement with a PC generator feeding a DEPTH-entry prefetch queue. The queue decouples instruction memory from a stallable decode stage. Flush, branch/jump redirect, exception vectoring and interrupt vectoring are handled in one place, and the block reports the EPC of the interrupted instruction.

## Interface
- DEPTH, 4, prefetch queue entries; power of two, ≥2
- RESET_VEC, 32'h8000_0000, PC after reset (supervisor bit set)
- IRQ_VEC, 32'h8000_0004, interrupt entry PC
- EXC_VEC, 32'h8000_0008, illegal-op/exception entry PC
- CLK  in  1  single clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- imem_addr  out  32  fetch address to ROM (combinational read)
- imem_data  in  32  instruction at imem_addr, same cycle
- out_valid  out  1  head entry valid
- out_ready  in  1  decode accepts head this cycle
- out_instr  out  32  head instruction
- out_pc  out  32  head PC
- out_pcplus4  out  32  head PC+4, bit 31 preserved
- out_super  out  1  out_pc[31]
- redirect_valid  in  1  branch/jump/jr taken by the head instruction
- redirect_pc  in  32  target, used verbatim (bit 31 included)
- exc  in  1  head instruction is illegal
- irq  in  1  level interrupt request
- epc_valid  out  1  one-cycle pulse: exception/interrupt taken
- epc  out  32  address to resume at, held until next take

## Operation
- PC+4 rule everywhere: {pc[31], pc[30:0]+31'd4}. No carry into bit 31; wraps within the half.
- Fetch: when no flush event occurs and (count<DEPTH or pop this cycle), push {fpc, imem_data} and fpc ← fpc+4.
- Pop: out_valid & out_ready with no flush event.
- Simultaneous push and pop: count unchanged. Full and no pop: no fetch, fpc holds.
- Flush events, priority exc > redirect_valid > irq. Any flush event clears the queue (count←0), suppresses push and pop, and loads fpc.
  - exc (qualified by out_valid): fpc←EXC_VEC; epc←out_pc+4; epc_valid=1.
  - redirect_valid (qualified by out_valid & out_ready): fpc←redirect_pc. Redirect asserted without out_valid is ignored.
  - irq taken when irq=1 and current super=0. Current super = out_pc[31] if out_valid, else fpc[31]. Effect: fpc←IRQ_VEC; epc←(out_valid ? out_pc : fpc); epc_valid=1. The head instruction is not executed.
- After an irq take, fpc[31]=1, so irq stays masked until software returns via jr to an address with bit 31 clear.
- Reset values: fpc=RESET_VEC, count=0, rd/wr pointers 0, out_valid=0, epc=0, epc_valid=0. out_instr/out_pc are don't-care while out_valid=0.
- Reset asserted mid-operation: immediate asynchronous return to reset state. Queue contents are discarded.

## Timing
- imem_addr = fpc, combinational.
- From reset release, first rising edge pushes entry RESET_VEC; out_valid=1 after that edge.
- Flush at edge N: fpc=target during cycle N+1, target pushed at edge N+1, out_valid with out_pc=target after edge N+1. Redirect penalty is one bubble cycle.
- epc_valid is high for exactly the cycle after the take edge. epc is registered.
- Full-throughput: with out_ready held 1, one instruction per cycle, no bubbles.

## Structure
- Shared package mips_pkg: RESET_VEC/IRQ_VEC/EXC_VEC constants, the pc_plus4 function, and the fetch_entry_t struct {pc[31:0], instr[31:0]}.
- One sub-module, fetch_queue: a synchronous FIFO of fetch_entry_t.
  - Parameter DEPTH; pointers $clog2(DEPTH) bits with natural wrap; count $clog2(DEPTH)+1 bits.
  - Synchronous flush input; Reset_n asynchronous.
- The top contains the fpc register, the flush-priority logic and the EPC register.

## Test plan
- Reset, out_ready=1, ROM returns addr^32'hFFFF_FFFF → out_pc sequence 8000_0000, 8000_0004, 8000_0008, one per cycle, instr matching.
- out_ready=0 for 10 cycles → count saturates at DEPTH=4, fpc holds at 8000_0010. Release → queued PCs 8000_0000..8000_000C come out in order with no duplicates.
- Redirect at head pc 8000_0008 to 0000_0100 → exactly one bubble, next out_pc=0000_0100, then 0000_0104. None of the stale 8000_000C..8000_0014 entries appear.
- Running at user PC 0000_0200 with queue holding 0000_0200..020C, assert irq → epc_valid pulse, epc=0000_0200, next out_pc=8000_0004. irq still high while in 8xxx_xxxx → no further epc_valid.
- exc and redirect_valid both asserted at head 0000_0300 → EXC_VEC wins, epc=0000_0304. irq high in the same cycle is ignored.
- PC wrap: redirect to 7FFF_FFFC → next out_pc 0000_0000 (bit 31 preserved); from FFFF_FFFC → 8000_0000. Also assert Reset_n=0 mid-stream → out_valid drops immediately, restart at 8000_0000.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared fetch-path definitions: reset/trap vectors, the PC+4 rule and the queue entry type.
package mips_pkg;

    localparam logic [31:0] RESET_VEC = 32'h8000_0000;
    localparam logic [31:0] IRQ_VEC   = 32'h8000_0004;
    localparam logic [31:0] EXC_VEC   = 32'h8000_0008;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Bit 31 is the supervisor bit; the increment never carries into it.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return {pc[31], pc[30:0] + 31'd4};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of fetch entries with a synchronous flush; head entry is read combinationally.
module fetch_queue
    import mips_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         CLK,
    input  logic         Reset_n,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t wr_entry,
    input  logic         pop,
    output fetch_entry_t rd_entry,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;

    assign rd_entry = mem[rd_ptr];
    assign full     = (count == (PW+1)'(DEPTH));
    assign empty    = (count == '0);

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked entirely by count.
    always_ff @(posedge CLK) begin
        if (push && !flush) mem[wr_ptr] <= wr_entry;
    end

endmodule

// File: rtl/prefetch_fetch_unit.sv
// Instruction-fetch front end: PC generator, prefetch queue, flush priority and EPC capture.
module prefetch_fetch_unit #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] RESET_VEC = mips_pkg::RESET_VEC,
    parameter logic [31:0] IRQ_VEC   = mips_pkg::IRQ_VEC,
    parameter logic [31:0] EXC_VEC   = mips_pkg::EXC_VEC
) (
    input  logic        CLK,
    input  logic        Reset_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pcplus4,
    output logic        out_super,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        exc,
    input  logic        irq,
    output logic        epc_valid,
    output logic [31:0] epc
);

    import mips_pkg::*;

    logic [31:0]  fpc;
    fetch_entry_t head;
    fetch_entry_t wr_entry;
    logic         q_full;
    logic         q_empty;
    logic         push;
    logic         pop;
    logic         flush;
    logic         exc_take;
    logic         redir_take;
    logic         irq_take;
    logic         cur_super;

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .CLK      (CLK),
        .Reset_n  (Reset_n),
        .flush    (flush),
        .push     (push),
        .wr_entry (wr_entry),
        .pop      (pop),
        .rd_entry (head),
        .full     (q_full),
        .empty    (q_empty)
    );

    assign imem_addr   = fpc;
    assign out_valid   = !q_empty;
    assign out_pc      = head.pc;
    assign out_instr   = head.instr;
    assign out_pcplus4 = pc_plus4(head.pc);
    assign out_super   = head.pc[31];

    // Flush priority: exception, then taken redirect, then interrupt.
    always_comb begin
        cur_super  = out_valid ? head.pc[31] : fpc[31];
        exc_take   = exc & out_valid;
        redir_take = redirect_valid & out_valid & out_ready & ~exc_take;
        irq_take   = irq & ~cur_super & ~exc_take & ~redir_take;
        flush      = exc_take | redir_take | irq_take;
        pop        = out_valid & out_ready & ~flush;
        push       = ~flush & (~q_full | pop);
        wr_entry   = '{pc: fpc, instr: imem_data};
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            fpc <= RESET_VEC;
        end else if (exc_take) begin
            fpc <= EXC_VEC;
        end else if (redir_take) begin
            fpc <= redirect_pc;
        end else if (irq_take) begin
            fpc <= IRQ_VEC;
        end else if (push) begin
            fpc <= pc_plus4(fpc);
        end
    end

    // An exception resumes after the faulting instruction; an interrupt re-executes the head.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            epc_valid <= 1'b0;
            epc       <= '0;
        end else begin
            epc_valid <= exc_take | irq_take;
            if (exc_take) begin
                epc <= pc_plus4(head.pc);
            end else if (irq_take) begin
                epc <= out_valid ? head.pc : fpc;
            end
        end
    end

endmodule

// File: tb/tb_prefetch_fetch_unit.sv
// Randomized and directed bench for prefetch_fetch_unit against a queue-based behavioural model.
module tb_prefetch_fetch_unit;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RV    = 32'h8000_0000;
    localparam logic [31:0] IV    = 32'h8000_0004;
    localparam logic [31:0] EV    = 32'h8000_0008;

    logic        CLK = 1'b0;
    logic        Reset_n = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pcplus4;
    logic        out_super;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        exc = 1'b0;
    logic        irq = 1'b0;
    logic        epc_valid;
    logic [31:0] epc;

    int total = 0;
    int bad   = 0;

    // Model state: queued PCs, fetch PC, EPC and its pulse.
    logic [31:0] mq[$];
    logic [31:0] m_fpc;
    logic [31:0] m_epc;
    logic        m_epcv;

    always #5 CLK = ~CLK;

    assign imem_data = imem_addr ^ 32'hFFFF_FFFF;

    prefetch_fetch_unit #(.DEPTH(DEPTH)) dut (
        .CLK            (CLK),
        .Reset_n        (Reset_n),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pcplus4    (out_pcplus4),
        .out_super      (out_super),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .exc            (exc),
        .irq            (irq),
        .epc_valid      (epc_valid),
        .epc            (epc)
    );

    function automatic logic [31:0] p4(input logic [31:0] pc);
        logic [31:0] r;
        r = pc;
        r[30:0] = pc[30:0] + 31'd4;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_fpc  = RV;
        m_epc  = '0;
        m_epcv = 1'b0;
    endtask

    task automatic compare();
        chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        chk("imem_addr", imem_addr, m_fpc);
        chk("epc_valid", 32'(epc_valid), 32'(m_epcv));
        chk("epc", epc, m_epc);
        if (mq.size() != 0) begin
            chk("out_pc", out_pc, mq[0]);
            chk("out_instr", out_instr, ~mq[0]);
            chk("out_pcplus4", out_pcplus4, p4(mq[0]));
            chk("out_super", 32'(out_super), 32'(mq[0][31]));
        end
    endtask

    // Advance the model one clock using the inputs about to be seen at the edge.
    task automatic model_step(input bit rdy, input bit rv, input logic [31:0] rpc,
                              input bit ex, input bit iq);
        bit has, sup;
        has    = (mq.size() != 0);
        sup    = has ? mq[0][31] : m_fpc[31];
        m_epcv = 1'b0;
        if (ex && has) begin
            m_epc  = p4(mq[0]);
            m_epcv = 1'b1;
            mq.delete();
            m_fpc  = EV;
        end else if (rv && has && rdy) begin
            mq.delete();
            m_fpc = rpc;
        end else if (iq && !sup) begin
            m_epc  = has ? mq[0] : m_fpc;
            m_epcv = 1'b1;
            mq.delete();
            m_fpc  = IV;
        end else begin
            if (has && rdy) void'(mq.pop_front());
            if (mq.size() < DEPTH) begin
                mq.push_back(m_fpc);
                m_fpc = p4(m_fpc);
            end
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input bit rdy, input bit rv = 0, input logic [31:0] rpc = '0,
                        input bit ex = 0, input bit iq = 0);
        compare();
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        exc            = ex;
        irq            = iq;
        model_step(rdy, rv, rpc, ex, iq);
        @(negedge CLK);
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #3;
        Reset_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_epc_valid", 32'(epc_valid), 32'd0);
        chk("rst_imem_addr", imem_addr, RV);
        chk("rst_epc", epc, 32'd0);
        model_reset();
        out_ready = 1'b0; redirect_valid = 1'b0; exc = 1'b0; irq = 1'b0;
        repeat (2) @(negedge CLK);
        Reset_n = 1'b1;
    endtask

    initial begin
        logic [31:0] r;
        model_reset();
        do_reset();

        // Streaming from reset.
        step(1); chk("lit_first", out_pc, 32'h8000_0000);
        chk("lit_first_instr", out_instr, 32'h7FFF_FFFF);
        step(1); chk("lit_second", out_pc, 32'h8000_0004);
        step(1); chk("lit_third", out_pc, 32'h8000_0008);

        // Stall until full, then drain in order.
        do_reset();
        repeat (10) step(0);
        chk("lit_full_fpc", imem_addr, 32'h8000_0010);
        chk("lit_full_head", out_pc, 32'h8000_0000);
        step(1); chk("lit_drain1", out_pc, 32'h8000_0004);
        repeat (6) step(1);

        // Redirect with one bubble.
        do_reset();
        repeat (3) step(1);
        chk("lit_redir_head", out_pc, 32'h8000_0008);
        step(1, 1, 32'h0000_0100);
        chk("lit_bubble", 32'(out_valid), 32'd0);
        step(1); chk("lit_redir_t", out_pc, 32'h0000_0100);
        step(1); chk("lit_redir_t4", out_pc, 32'h0000_0104);

        // Interrupt from user mode, then masked while supervisor.
        step(1, 1, 32'h0000_0200);
        repeat (5) step(0);
        chk("lit_user_fpc", imem_addr, 32'h0000_0210);
        step(0, 0, '0, 0, 1);
        chk("lit_irq_pulse", 32'(epc_valid), 32'd1);
        chk("lit_irq_epc", epc, 32'h0000_0200);
        step(1, 0, '0, 0, 1);
        chk("lit_irq_vec", out_pc, 32'h8000_0004);
        chk("lit_irq_once", 32'(epc_valid), 32'd0);
        repeat (4) step(1, 0, '0, 0, 1);
        chk("lit_irq_masked", 32'(epc_valid), 32'd0);

        // Exception beats redirect and interrupt.
        step(1, 1, 32'h0000_0300);
        step(1); chk("lit_exc_head", out_pc, 32'h0000_0300);
        step(1, 1, 32'h0000_0500, 1, 1);
        chk("lit_exc_pulse", 32'(epc_valid), 32'd1);
        chk("lit_exc_epc", epc, 32'h0000_0304);
        step(1); chk("lit_exc_vec", out_pc, 32'h8000_0008);

        // PC wrap within each half.
        step(1, 1, 32'h7FFF_FFFC);
        step(1); chk("lit_wrap_lo_head", out_pc, 32'h7FFF_FFFC);
        step(1); chk("lit_wrap_lo", out_pc, 32'h0000_0000);
        step(1, 1, 32'hFFFF_FFFC);
        step(1); chk("lit_wrap_hi_p4", out_pcplus4, 32'h8000_0000);
        step(1); chk("lit_wrap_hi", out_pc, 32'h8000_0000);

        // Mid-stream reset.
        repeat (3) step(1);
        do_reset();
        step(1); chk("lit_restart", out_pc, 32'h8000_0000);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            r = $urandom;
            r[1:0] = 2'b00;
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0), r,
                 ($urandom_range(0, 29) == 0), ($urandom_range(0, 9) == 0));
        end
        step(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
